// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instr/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOCK, RESP} arb_state_e;
    typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_e;

    localparam logic [31:0] MEM_ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Response watchdog: counts cycles spent waiting for rvalid and pulses
// timeout on the RSP_TIMEOUT-th waiting cycle.
module mem_arb_watchdog #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(RSP_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

    // count is 0 on the first waiting cycle, so LIMIT marks the last allowed one
    assign timeout = en && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/LSU) arbiter onto one memory port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on ties; default is data-over-instr.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                req,
    input  logic                reset,
    input  logic                instr_req_in,
    input  logic [ADDR_W-1:0]   instr_addr_in,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                data_req_in,
    input  logic [ADDR_W-1:0]   data_addr_in,
    input  logic                data_we_in,
    input  logic [DATA_W/8-1:0] data_be_in,
    input  logic [DATA_W-1:0]   data_wdata_in,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_in,
    input  logic                mem_rvalid_in,
    input  logic [DATA_W-1:0]   mem_rdata_in,
    output logic                err_o
);

    arb_state_e state, state_d;
    arb_owner_e owner, owner_d, winner, sel;
    logic       issue, sel_req, rsp_fire, timeout;
    logic [DATA_W-1:0] rsp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_e last_owner, last_owner_d;

    always_comb begin
        if (instr_req_in && data_req_in)
            winner = (last_owner == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        else
            winner = data_req_in ? OWN_DATA : OWN_INSTR;
    end
`else
    assign winner = data_req_in ? OWN_DATA : OWN_INSTR;
`endif

    mem_arb_watchdog #(.RSP_TIMEOUT(RSP_TIMEOUT)) u_watchdog (
        .clk     (req),
        .rst_n   (reset),
        .clr     (state != RESP),
        .en      (state == RESP),
        .timeout (timeout)
    );

    always_comb begin
        state_d  = state;
        owner_d  = owner;
        issue    = 1'b0;
        rsp_fire = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner;
`endif
        sel     = (state == IDLE) ? winner : owner;
        sel_req = (sel == OWN_DATA) ? data_req_in : instr_req_in;

        case (state)
            IDLE: begin
                // a stray mem_rvalid_in here is deliberately ignored
                if (instr_req_in || data_req_in) begin
                    issue   = 1'b1;
                    owner_d = winner;
                    state_d = mem_gnt_in ? RESP : LOCK;
                end
            end
            LOCK: begin
                if (!sel_req) begin
                    state_d = IDLE;
                end else begin
                    issue = 1'b1;
                    if (mem_gnt_in)
                        state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_in || timeout) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_owner_d = owner;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by reset so an asserted reset blanks them immediately.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_addr_o     = '0;
        mem_we_o       = 1'b0;
        mem_be_o       = '0;
        mem_wdata_o    = '0;
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        instr_rdata_o  = '0;
        data_rdata_o   = '0;
        err_o          = 1'b0;
        rsp_data       = mem_rvalid_in ? mem_rdata_in : DATA_W'(MEM_ARB_ERR_DATA);

        if (reset && issue) begin
            mem_req_o = 1'b1;
            if (sel == OWN_DATA) begin
                mem_addr_o  = data_addr_in;
                mem_we_o    = data_we_in;
                mem_be_o    = data_be_in;
                mem_wdata_o = data_wdata_in;
                data_gnt_o  = mem_gnt_in;
            end else begin
                mem_addr_o  = instr_addr_in;
                mem_be_o    = '1;
                instr_gnt_o = mem_gnt_in;
            end
        end

        if (reset && rsp_fire) begin
            err_o = !mem_rvalid_in;
            if (owner == OWN_DATA) begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = rsp_data;
            end else begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = rsp_data;
            end
        end
    end

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= OWN_INSTR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= OWN_INSTR;
`endif
        end else begin
            state <= state_d;
            owner <= owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= last_owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    typedef struct {
        bit          port;  // 0 instr, 1 data
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t g;
    rexp_t r;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RSP_TIMEOUT(4)) dut (
        .req(clk), .reset(rst_n),
        .instr_req_in(instr_req), .instr_addr_in(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_in(data_req), .data_addr_in(data_addr), .data_we_in(data_we),
        .data_be_in(data_be), .data_wdata_in(data_wdata),
        .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_gnt_in(mem_gnt), .mem_rvalid_in(mem_rvalid), .mem_rdata_in(mem_rdata),
        .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(bit port, logic [31:0] addr, logic we, logic [3:0] be, logic [31:0] wd);
        gq.push_back('{port, addr, we, be, wd});
    endtask

    task automatic push_r(bit port, logic [31:0] data, bit e, int c);
        rq.push_back('{port, data, e, c});
    endtask

    // Monitor: grants and responses are checked against the queues.
    always @(negedge clk) begin
        if (instr_gnt || data_gnt || (mem_req && mem_gnt)) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", 1, 0);
            end else begin
                g = gq.pop_front();
                chk("gnt_port", {instr_gnt, data_gnt}, g.port ? 2'b01 : 2'b10);
                chk("gnt_mem_req", mem_req, 1);
                chk("gnt_addr", mem_addr, g.addr);
                chk("gnt_we", mem_we, g.we);
                chk("gnt_be", mem_be, g.be);
                chk("gnt_wdata", mem_wdata, g.wdata);
            end
        end
        if (instr_rvalid || data_rvalid) begin
            if (rq.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                r = rq.pop_front();
                chk("rsp_port", {instr_rvalid, data_rvalid}, r.port ? 2'b01 : 2'b10);
                chk("rsp_data", r.port ? data_rdata : instr_rdata, r.data);
                chk("rsp_other_rdata", r.port ? instr_rdata : data_rdata, 0);
                chk("rsp_err", err, r.err);
                chk("rsp_cycle", cyc_n, r.cyc);
            end
        end else if (err) begin
            chk("err_without_rvalid", 1, 0);
        end
    end

    initial begin
        bit first_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        rst_n = 1'b0;
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_addr = 0; data_we = 0; data_be = 0; data_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        step();
        step();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_gnts", {instr_gnt, data_gnt}, 0);
        chk("rst_rvalids", {instr_rvalid, data_rvalid, err}, 0);
        chk("rst_rdata", {instr_rdata, data_rdata}, 0);
        chk("rst_mem_bus", {mem_addr, mem_we, mem_be, mem_wdata}, 0);
        step();
        rst_n = 1'b1;
        step();

        // instr only, immediate grant, 2-cycle access
        instr_req = 1; instr_addr = 32'h10; mem_gnt = 1;
        push_g(0, 32'h10, 0, 4'hF, 0);
        push_r(0, 32'h0050_0093, 0, cyc_n + 1);
        step();
        instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        step();
        mem_rvalid = 0; mem_rdata = 0;

        // data read 0x104, full byte enables
        data_req = 1; data_addr = 32'h104; data_we = 0; data_be = 4'hF; data_wdata = 0; mem_gnt = 1;
        push_g(1, 32'h104, 0, 4'hF, 0);
        push_r(1, 32'h1122_3344, 0, cyc_n + 1);
        step();
        data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1122_3344;
        step();
        mem_rvalid = 0;

        // simultaneous requests, last owner was data
        instr_req = 1; instr_addr = 32'h20;
        data_req = 1; data_addr = 32'h100; data_we = 1; data_be = 4'hF; data_wdata = 32'hAB;
        mem_gnt = 1;
        if (first_data) begin
            push_g(1, 32'h100, 1, 4'hF, 32'hAB);
            push_r(1, 32'hA1, 0, cyc_n + 1);
        end else begin
            push_g(0, 32'h20, 0, 4'hF, 0);
            push_r(0, 32'hA1, 0, cyc_n + 1);
        end
        step();
        if (first_data) data_req = 0; else instr_req = 0;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA1;
        step();
        mem_rvalid = 0; mem_gnt = 1;
        if (first_data) begin
            push_g(0, 32'h20, 0, 4'hF, 0);
            push_r(0, 32'hB2, 0, cyc_n + 1);
        end else begin
            push_g(1, 32'h100, 1, 4'hF, 32'hAB);
            push_r(1, 32'hB2, 0, cyc_n + 1);
        end
        step();
        instr_req = 0; data_req = 0; data_we = 0; data_wdata = 0;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hB2;
        step();
        mem_rvalid = 0;

        // LOCK: grant withheld 3 cycles, data arrives mid-lock, stray rvalid ignored
        instr_req = 1; instr_addr = 32'h30; mem_gnt = 0;
        step();
        data_req = 1; data_addr = 32'h200; data_we = 0; data_be = 4'hF;
        step();
        mem_rvalid = 1; mem_rdata = 32'h99;
        @(negedge clk);
        chk("lock_addr_held", mem_addr, 32'h30);
        chk("lock_req_held", mem_req, 1);
        chk("lock_stray_rvalid", {instr_rvalid, data_rvalid}, 0);
        step();
        mem_rvalid = 0; mem_gnt = 1;
        push_g(0, 32'h30, 0, 4'hF, 0);
        push_r(0, 32'h33, 0, cyc_n + 1);
        step();
        instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h33;
        step();
        mem_rvalid = 0; mem_gnt = 1;
        push_g(1, 32'h200, 0, 4'hF, 0);
        push_r(1, 32'h44, 0, cyc_n + 1);
        step();
        data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h44;
        step();
        mem_rvalid = 0;

        // watchdog: no rvalid, timeout 4 cycles after grant
        instr_req = 1; instr_addr = 32'h40; mem_gnt = 1;
        push_g(0, 32'h40, 0, 4'hF, 0);
        push_r(0, 32'hDEAD_BEEF, 1, cyc_n + 4);
        step();
        instr_req = 0; mem_gnt = 0;
        step();
        step();
        step();
        step();
        mem_rvalid = 1; mem_rdata = 32'h55;
        @(negedge clk);
        chk("late_rvalid_dropped", {instr_rvalid, data_rvalid, err}, 0);
        step();
        mem_rvalid = 0;

        // reset asserted while in RESP
        instr_req = 1; instr_addr = 32'h50; mem_gnt = 1;
        push_g(0, 32'h50, 0, 4'hF, 0);
        step();
        rst_n = 0;
        data_req = 1; data_addr = 32'h300; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h66;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_gnts", {instr_gnt, data_gnt}, 0);
        chk("arst_rvalids", {instr_rvalid, data_rvalid, err}, 0);
        chk("arst_bus", {mem_addr, instr_rdata, data_rdata}, 0);
        step();
        instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #1;
        rst_n = 1;
        step();
        data_req = 1; data_addr = 32'h300; data_we = 0; data_be = 4'hF; mem_gnt = 1;
        push_g(1, 32'h300, 0, 4'hF, 0);
        push_r(1, 32'h77, 0, cyc_n + 1);
        step();
        data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        step();
        mem_rvalid = 0;
        step();
        step();

        chk("grants_drained", gq.size(), 0);
        chk("responses_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
